// File: rtl/mem_read_arbiter_pkg.sv
// rtl/mem_read_arbiter_pkg.sv - shared types and sizing for the memory read-port arbiter
package mspu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int MAX_REQ = 4;
    localparam int IDXW    = $clog2(MAX_REQ);

endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// rtl/mem_read_arbiter_rr_pick.sv - combinational round-robin select: first requester at or after rr_ptr
module rr_pick
    import mspu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    rr_ptr,
    output logic               found,
    output logic [IDXW-1:0]    winner
);

    logic [IDXW:0] idx;
    logic          hit;

    // rr_ptr is always below NUM_REQ, so a single wrap subtraction is enough.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, rr_ptr} + (IDXW+1)'(off);
            if (idx >= (IDXW+1)'(NUM_REQ)) begin
                idx = idx - (IDXW+1)'(NUM_REQ);
            end
            hit = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (idx[IDXW-1:0] == IDXW'(i)) begin
                    hit = req[i];
                end
            end
            if (hit && !found) begin
                found  = 1'b1;
                winner = idx[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - burst-granular arbiter for the shared data-memory read port with tagged returns
module mem_read_arbiter
    import mspu_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_oe,
    output logic [NUM_REQ-1:0]    grant,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_oe,
    input  logic [DW-1:0]         mem_q,
    output logic [DW-1:0]         rd_q,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic                  busy
);

    state_t                             state;
    logic   [IDXW-1:0]                  owner;
    logic   [IDXW-1:0]                  rr_ptr;
    logic   [IDXW-1:0]                  mem_tag;
    logic   [RD_LATENCY-1:0]            pipe_v;
    logic   [RD_LATENCY-1:0][IDXW-1:0]  pipe_tag;

    logic                  found;
    logic [IDXW-1:0]       winner;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  own_req;
    logic                  own_oe;
    logic [AW-1:0]         own_addr;
    logic [IDXW-1:0]       rr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    // The one-hot grant doubles as the owner mux select, so no variable indexing is needed.
    always_comb begin
        own_req    = 1'b0;
        own_oe     = 1'b0;
        own_addr   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (winner == IDXW'(i));
            if (grant[i]) begin
                own_req  = req[i];
                own_oe   = req_oe[i];
                own_addr = req_addr[AW*i +: AW];
            end
        end
    end

    assign rr_next = (owner == IDXW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            mem_addr <= '0;
            mem_oe   <= 1'b0;
            mem_tag  <= '0;
        end else begin
            mem_oe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_OWN;
                        owner <= winner;
                        grant <= win_onehot;
                    end
                end
                ST_OWN: begin
                    mem_addr <= own_addr;
                    mem_oe   <= own_oe;
                    mem_tag  <= owner;
                    if (!own_req) begin
                        state  <= ST_GAP;
                        grant  <= '0;
                        rr_ptr <= rr_next;
                    end
                end
                ST_GAP: begin
                    if (found) begin
                        state <= ST_OWN;
                        owner <= winner;
                        grant <= win_onehot;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Each read carries its owner tag, so returns land correctly across a handover.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v   <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_v[0]   <= mem_oe;
            pipe_tag[0] <= mem_tag;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_valid[i] = pipe_v[RD_LATENCY-1] && (pipe_tag[RD_LATENCY-1] == IDXW'(i));
        end
    end

    assign rd_q = mem_q;
    assign busy = (state != ST_IDLE) || mem_oe || (|pipe_v);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - directed self-checking bench for mem_read_arbiter
module tb_mem_read_arbiter;

    localparam int NR  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_oe;
    logic [NR-1:0]    grant;
    logic [AW-1:0]    mem_addr;
    logic             mem_oe;
    logic [DW-1:0]    mem_q;
    logic [DW-1:0]    rd_q;
    logic [NR-1:0]    rd_valid;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0]    a_d [LAT];
    logic [NR+DW-1:0] ret_q [$];

    mem_read_arbiter #(
        .NUM_REQ    (NR),
        .AW         (AW),
        .DW         (DW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .req_oe   (req_oe),
        .grant    (grant),
        .mem_addr (mem_addr),
        .mem_oe   (mem_oe),
        .mem_q    (mem_q),
        .rd_q     (rd_q),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    // Memory with LAT cycles from registered address to data.
    always @(posedge clk) begin
        for (int k = LAT-1; k > 0; k--) a_d[k] <= a_d[k-1];
        a_d[0] <= mem_addr;
    end
    assign mem_q = dat(a_d[LAT-1]);

    always @(negedge clk) begin
        if (|rd_valid) ret_q.push_back({rd_valid, rd_q});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[AW*i +: AW] = a;
    endtask

    task automatic do_reset;
        req = '0; req_oe = '0; req_addr = '0;
        reset_n = 1'b0;
        tick; tick;
        reset_n = 1'b1;
        ret_q.delete();
        tick;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick;
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    function automatic int oh2idx(input logic [NR-1:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    initial begin
        int errs;
        int bad;
        int own;
        int cnt;
        int dead;
        int rv1;

        req = '0; req_oe = '0; req_addr = '0; reset_n = 1'b0;
        tick; tick;
        check("rst_grant", grant, 0);
        check("rst_mem_oe", mem_oe, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick;

        // Single requester, 512-word burst from 0x3800.
        req = 3'b001;
        tick;
        check("t1_grant", grant, 3'b001);
        for (int k = 0; k < 512; k++) begin
            set_addr(0, 32'h3800 + 4*k);
            req_oe[0] = 1'b1;
            tick;
            if (k == 0) begin
                check("t1_first_mem_oe", mem_oe, 1'b1);
                check("t1_first_mem_addr", mem_addr, 32'h3800);
            end
            if (k == 2) check("t1_no_early_valid", rd_valid, 0);
            if (k == 3) begin
                check("t1_first_valid", rd_valid, 3'b001);
                check("t1_first_data", rd_q, 32'hC3C3_3800);
            end
        end
        req_oe = '0; req = '0;
        tick;
        check("t1_gap_grant", grant, 0);
        wait_idle("t1_busy_low");
        check("t1_count", ret_q.size(), 512);
        errs = 0; bad = 0;
        for (int k = 0; k < ret_q.size() && k < 512; k++) begin
            if (ret_q[k][DW-1:0] !== dat(32'h3800 + 4*k)) errs++;
            if (ret_q[k][NR+DW-1:DW] !== 3'b001) bad++;
        end
        check("t1_order_errs", errs, 0);
        check("t1_only_rd_valid0", bad, 0);

        // Contention from reset: lowest index first, one GAP cycle, then handover.
        do_reset;
        req = 3'b011;
        tick;
        check("t2_first_grant", grant, 3'b001);
        tick;
        req = 3'b010;
        tick;
        check("t2_gap", grant, 0);
        tick;
        check("t2_handover", grant, 3'b010);
        req = '0;
        tick;
        wait_idle("t2_busy_low");

        // Round-robin fairness with three continuous requesters, 4-word bursts.
        do_reset;
        req = 3'b111;
        for (int b = 0; b < 6; b++) begin
            cnt = 0;
            while (grant == 0 && cnt < 10) begin
                tick;
                cnt++;
            end
            own = oh2idx(grant);
            check("t3_rr_order", own, b % 3);
            if (own > 2) own = 0;
            for (int w = 0; w < 4; w++) begin
                set_addr(own, 32'h1000*own + 4*w);
                req_oe[own] = 1'b1;
                tick;
            end
            req_oe = '0;
            req[own] = 1'b0;
            tick;
            check("t3_gap", grant, 0);
            req[own] = 1'b1;
        end
        req = '0;
        tick;
        tick;
        wait_idle("t3_busy_low");
        check("t3_count", ret_q.size(), 24);

        // Tag integrity: release with 3 reads in flight, then requester 1 reads once.
        do_reset;
        req = 3'b011;
        tick;
        check("t4_grant0", grant, 3'b001);
        for (int w = 0; w < 3; w++) begin
            set_addr(0, 32'h2000 + 4*w);
            req_oe[0] = 1'b1;
            tick;
        end
        req_oe = '0;
        req[0] = 1'b0;
        tick;
        check("t4_gap", grant, 0);
        tick;
        check("t4_grant1", grant, 3'b010);
        check("t4_old_owner_return", rd_valid, 3'b001);
        set_addr(1, 32'h5000);
        req_oe[1] = 1'b1;
        tick;
        req_oe = '0; req = '0;
        tick;
        wait_idle("t4_busy_low");
        check("t4_count", ret_q.size(), 4);
        if (ret_q.size() == 4) begin
            check("t4_ret0", ret_q[0], {3'b001, 32'hC3C3_2000});
            check("t4_ret1", ret_q[1], {3'b001, 32'hC3C3_2004});
            check("t4_ret2", ret_q[2], {3'b001, 32'hC3C3_2008});
            check("t4_ret3", ret_q[3], {3'b010, 32'hC3C3_5000});
        end

        // Non-owner strobe must be ignored.
        do_reset;
        req = 3'b011;
        tick;
        check("t5_grant0", grant, 3'b001);
        dead = 0; rv1 = 0;
        for (int w = 0; w < 8; w++) begin
            set_addr(0, 32'h4000 + 4*w);
            req_oe[0] = 1'b1;
            set_addr(1, 32'hDEAD);
            req_oe[1] = 1'b1;
            tick;
            if (mem_addr == 32'hDEAD) dead++;
            if (rd_valid[1]) rv1++;
        end
        req_oe = '0; req = '0;
        tick;
        if (mem_addr == 32'hDEAD) dead++;
        wait_idle("t5_busy_low");
        check("t5_no_dead_addr", dead, 0);
        check("t5_no_rd_valid1", rv1, 0);
        check("t5_count", ret_q.size(), 8);

        // Reset at read 100 of a 512-word burst.
        do_reset;
        req = 3'b001;
        tick;
        for (int k = 0; k <= 100; k++) begin
            set_addr(0, 32'h3800 + 4*k);
            req_oe[0] = 1'b1;
            tick;
        end
        check("t6_pre_valid", rd_valid, 3'b001);
        reset_n = 1'b0;
        #1;
        check("t6_grant", grant, 0);
        check("t6_mem_oe", mem_oe, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_rd_valid", rd_valid, 0);
        check("t6_busy", busy, 0);
        req = '0; req_oe = '0;
        tick; tick;
        reset_n = 1'b1;
        req = 3'b010;
        tick;
        check("t6_fresh_grant", grant, 3'b010);
        req = '0;
        tick;
        wait_idle("t6_busy_low");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single 32-bit data-memory read port (mem_addr/mem_oe/mem_q) between up to NUM_REQ burst readers. Typical readers are the 32-to-512 width converter's 512-word fetch and a host/debug reader. Each requester holds `req` for its whole burst, and ownership changes only at burst boundaries, so the requester sequences addresses exactly as if it owned the memory. Read data is broadcast, and a per-requester valid is tagged through a latency pipeline.

## Interface
Parameters:
- NUM_REQ, 2 — number of requesters, legal 2..4
- AW, 32 — address width
- DW, 32 — data width
- RD_LATENCY, 1 — cycles from registered mem_oe to mem_q valid, legal 1..3

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester burst request, held for the entire burst
- req_addr  in  NUM_REQ*AW  per-requester read address, slice i = [AW*i+AW-1:AW*i]
- req_oe  in  NUM_REQ  per-requester read strobe
- grant  out  NUM_REQ  registered one-hot ownership, all-zero when no owner
- mem_addr  out  AW  registered address to data memory
- mem_oe  out  1  registered read strobe to data memory
- mem_q  in  DW  memory read data
- rd_q  out  DW  equals mem_q, combinational passthrough
- rd_valid  out  NUM_REQ  one-hot, marks mem_q as belonging to requester i
- busy  out  1  high when state is not IDLE or any read is in flight

## Operation
- States:
  - IDLE: no owner, grant=0.
  - OWN: exactly one grant bit is set.
  - GAP: one dead cycle after a release, grant=0.
- IDLE → OWN: any req bit is set. The winner is picked round-robin as the first index ≥ rr_ptr, cyclic. grant is registered in the same transition.
- OWN → GAP: the owner's req is 0. The grant bit is cleared and rr_ptr becomes (owner+1) mod NUM_REQ.
- GAP → OWN when any req bit is set, otherwise GAP → IDLE. No grant is issued during the GAP cycle.
- Ownership is never preempted. A non-owner's req_oe/req_addr are ignored.
- Address path while in OWN: mem_addr ← req_addr[owner] and mem_oe ← req_oe[owner] every cycle. In IDLE/GAP, mem_oe ← 0 and mem_addr holds its value.
- Return path: a shift register of depth RD_LATENCY carries {mem_oe, owner index}. rd_valid[idx] = stage-out valid.
- In-flight reads still return to the old owner after a release or a new grant. Tagging guarantees there is no misrouting.
- After a release, the next owner's first mem_oe cannot collide with a prior owner's return, because each return is tagged.
- rr_ptr resets to 0, so the lowest index wins the first contention.
- Reset values (async assert, sync deassert use): state=IDLE, grant=0, mem_addr=0, mem_oe=0, rd_valid=0, busy=0, rr_ptr=0, pipeline cleared.
- Reset during a burst aborts all returns, and rd_valid is forced to 0 immediately.

## Timing
- req[i] is asserted at cycle t while the block is IDLE → grant[i]=1 at t+1.
- req_oe[i] is driven at cycle u while granted → mem_oe=1 at u+1 → mem_q/rd_valid[i] at u+1+RD_LATENCY.
- The owner drops req at cycle t → grant=0 at t+1 (GAP) → the next grant is at t+2 at the earliest.
- Worst-case handover is 2 cycles per burst boundary.
- If a requester drops req and re-raises it while others wait, the others win by round-robin.
- Throughput while owned is 1 read per cycle. A 512-word burst occupies the port for 512 + 1 (mem_oe register stage) + RD_LATENCY cycles.
- busy goes low one cycle after the last rd_valid when req=0.

## Structure
- Package mspu_arb_pkg:
  - state enum {IDLE, OWN, GAP}
  - MAX_REQ=4
  - localparam IDXW = $clog2(MAX_REQ)
- Sub-module rr_pick: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, winner index.
- The top holds the FSM, the address register stage and the return tag pipeline.

## Test plan
- Single requester: req[0] held, 512 reads at consecutive addresses from 0x3800 step 4 → grant[0] at t+1, rd_valid[0] 512 times in address order, rd_valid[1] never set.
- Contention from reset: req=2'b11 at the same cycle → grant=01 first. Requester 0 releases → GAP for one cycle, then grant=10.
- Round-robin fairness with NUM_REQ=3: all three request continuously with 4-word bursts → grant order 0,1,2,0,1,2.
- Tag integrity with RD_LATENCY=3: requester 0 releases while 3 reads are in flight → those 3 returns go to rd_valid[0], and requester 1's first return arrives later on rd_valid[1].
- Non-owner strobe: req_oe[1]=1 with address 0xDEAD while requester 0 owns → mem_addr never equals 0xDEAD and rd_valid[1] stays 0.
- Reset mid-burst: reset_n pulsed low at read 100 of 512 → all outputs 0 immediately, and a fresh req[1] after release is granted at the next cycle.
